pwm_ramp_ctrl: RTL and testbench

//  Command-driven duty sequencer for the pwm block. It ramps pwm_par in

---
 rtl/pwm_ramp_ctrl.sv | 143 ++++++++++++++
 tb/tb_pwm_ramp_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/pwm_ramp_ctrl.sv
// Command-driven duty sequencer: ramps pwm_par toward a target, holds there, then pulses done.
// One duty step per STEP_CYCLES clocks; commands are accepted only in IDLE without abort (cmd_ready), never queued.
module pwm_ramp_ctrl #(
    parameter int DUTY_MAX    = 100,
    parameter int STEP_CYCLES = 10
) (
    input  logic        sclk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [6:0]  cmd_target,
    input  logic [6:0]  cmd_step,
    input  logic [15:0] cmd_hold,
    input  logic        abort,
    output logic [31:0] pwm_par,
    output logic        busy,
    output logic        done
);

    localparam int TW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [6:0]    DMAX     = 7'(DUTY_MAX);
    localparam logic [TW-1:0] TICK_END = TW'(STEP_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, RAMP, HOLD} state_t;

    state_t        state, state_nxt;
    logic [6:0]    duty, duty_nxt;
    logic [6:0]    tgt, tgt_nxt;
    logic [6:0]    step, step_nxt;
    logic [15:0]   hold, hold_nxt;
    logic [TW-1:0] tick_cnt, tick_nxt;
    logic [15:0]   hold_cnt, hold_cnt_nxt;
    logic          done_nxt;
    logic          busy_nxt;

    logic          tick_end;
    logic [7:0]    up_sum;
    logic [7:0]    down_lim;
    logic [6:0]    step_val;
    logic [15:0]   hold_inc;

    assign cmd_ready = (state == IDLE) && !abort;
    assign pwm_par   = {25'b0, duty};
    assign tick_end  = (tick_cnt == TICK_END);
    assign hold_inc  = hold_cnt + 16'd1;

    // Both directions computed in 8 bits so the step saturates at tgt instead of wrapping.
    assign up_sum   = {1'b0, duty} + {1'b0, step};
    assign down_lim = {1'b0, tgt} + {1'b0, step};
    always_comb begin
        step_val = tgt;
        if (tgt > duty) begin
            step_val = (up_sum >= {1'b0, tgt}) ? tgt : up_sum[6:0];
        end else begin
            step_val = ({1'b0, duty} <= down_lim) ? tgt : (duty - step);
        end
    end

    always_comb begin
        state_nxt    = state;
        duty_nxt     = duty;
        tgt_nxt      = tgt;
        step_nxt     = step;
        hold_nxt     = hold;
        tick_nxt     = tick_cnt;
        hold_cnt_nxt = hold_cnt;
        done_nxt     = 1'b0;

        if (abort) begin
            state_nxt    = IDLE;
            duty_nxt     = 7'd0;
            tick_nxt     = '0;
            hold_cnt_nxt = 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        tgt_nxt      = (cmd_target > DMAX) ? DMAX : cmd_target;
                        step_nxt     = (cmd_step == 7'd0) ? 7'd1 : cmd_step;
                        hold_nxt     = cmd_hold;
                        tick_nxt     = '0;
                        hold_cnt_nxt = 16'd0;
                        state_nxt    = (tgt_nxt != duty) ? RAMP : HOLD;
                    end
                end
                RAMP: begin
                    tick_nxt = tick_end ? '0 : tick_cnt + 1'b1;
                    if (tick_end) begin
                        duty_nxt = step_val;
                        if (step_val == tgt) begin
                            state_nxt    = HOLD;
                            hold_cnt_nxt = 16'd0;
                        end
                    end
                end
                HOLD: begin
                    if (hold == 16'd0) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end else begin
                        tick_nxt = tick_end ? '0 : tick_cnt + 1'b1;
                        if (tick_end) begin
                            hold_cnt_nxt = hold_inc;
                            if (hold_inc == hold) begin
                                state_nxt = IDLE;
                                done_nxt  = 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
        busy_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            duty     <= 7'd0;
            tgt      <= 7'd0;
            step     <= 7'd1;
            hold     <= 16'd0;
            tick_cnt <= '0;
            hold_cnt <= 16'd0;
            done     <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_nxt;
            duty     <= duty_nxt;
            tgt      <= tgt_nxt;
            step     <= step_nxt;
            hold     <= hold_nxt;
            tick_cnt <= tick_nxt;
            hold_cnt <= hold_cnt_nxt;
            done     <= done_nxt;
            busy     <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Directed bench for pwm_ramp_ctrl with hand-computed duty/done/busy expectations.
module tb_pwm_ramp_ctrl;

    logic        sclk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [6:0]  cmd_target;
    logic [6:0]  cmd_step;
    logic [15:0] cmd_hold;
    logic        abort;
    logic [31:0] pwm_par;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;
    logic seen_done;

    pwm_ramp_ctrl #(.DUTY_MAX(100), .STEP_CYCLES(10)) dut (
        .sclk      (sclk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_target(cmd_target),
        .cmd_step  (cmd_step),
        .cmd_hold  (cmd_hold),
        .abort     (abort),
        .pwm_par   (pwm_par),
        .busy      (busy),
        .done      (done)
    );

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge sclk);
        #1;
    endtask

    task automatic send(input logic [6:0] t, input logic [6:0] s, input logic [15:0] h);
        cmd_valid  = 1'b1;
        cmd_target = t;
        cmd_step   = s;
        cmd_hold   = h;
    endtask

    initial begin
        rst        = 1'b1;
        cmd_valid  = 1'b0;
        cmd_target = 7'd0;
        cmd_step   = 7'd0;
        cmd_hold   = 16'd0;
        abort      = 1'b0;
        repeat (3) tick();
        check("rst_pwm", pwm_par, 0);
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_done", {31'b0, done}, 0);
        rst = 1'b0;
        tick();
        check("rel_ready", {31'b0, cmd_ready}, 1);

        // Ramp up 0 -> 50 by 10, hold 2 ticks
        send(7'd50, 7'd10, 16'd2);
        tick();
        cmd_valid = 1'b0;
        check("up_busy", {31'b0, busy}, 1);
        check("up_ready", {31'b0, cmd_ready}, 0);
        for (int k = 1; k <= 5; k++) begin
            repeat (9) tick();
            check("up_before", pwm_par, (k - 1) * 10);
            tick();
            check("up_step", pwm_par, k * 10);
        end
        repeat (19) tick();
        check("hold_nodone", {31'b0, done}, 0);
        check("hold_busy", {31'b0, busy}, 1);
        tick();
        check("up_done", {31'b0, done}, 1);
        check("up_busy_fall", {31'b0, busy}, 0);
        check("up_done_ready", {31'b0, cmd_ready}, 1);
        check("up_final", pwm_par, 50);
        tick();
        check("up_done_pulse", {31'b0, done}, 0);
        check("up_retain", pwm_par, 50);

        // Ramp down 50 -> 5 by 20, last step clamps
        send(7'd5, 7'd20, 16'd0);
        tick();
        cmd_valid = 1'b0;
        repeat (10) tick();
        check("dn_30", pwm_par, 30);
        repeat (10) tick();
        check("dn_10", pwm_par, 10);
        repeat (10) tick();
        check("dn_5", pwm_par, 5);
        check("dn_nodone_yet", {31'b0, done}, 0);
        tick();
        check("dn_done", {31'b0, done}, 1);
        tick();
        check("dn_retain", pwm_par, 5);

        // Target 120 clamps to 100, step 0 acts as 1
        send(7'd120, 7'd0, 16'd0);
        tick();
        cmd_valid = 1'b0;
        for (int k = 6; k <= 100; k++) begin
            repeat (10) tick();
            check("clamp_step", pwm_par, k);
        end
        tick();
        check("clamp_done", {31'b0, done}, 1);
        check("clamp_final", pwm_par, 100);

        // Get to 30, then start ramping to 80 and abort
        send(7'd30, 7'd70, 16'd0);
        tick();
        cmd_valid = 1'b0;
        repeat (10) tick();
        check("ab_setup", pwm_par, 30);
        tick();
        check("ab_setup_done", {31'b0, done}, 1);
        send(7'd80, 7'd10, 16'd5);
        tick();
        cmd_valid = 1'b0;
        repeat (5) tick();
        check("ab_pre_busy", {31'b0, busy}, 1);
        abort     = 1'b1;
        cmd_valid = 1'b1;
        send(7'd40, 7'd10, 16'd0);
        #1;
        check("ab_ready_low", {31'b0, cmd_ready}, 0);
        tick();
        abort     = 1'b0;
        cmd_valid = 1'b0;
        check("ab_pwm", pwm_par, 0);
        check("ab_busy", {31'b0, busy}, 0);
        check("ab_done", {31'b0, done}, 0);
        #1;
        check("ab_ready_back", {31'b0, cmd_ready}, 1);
        seen_done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            seen_done = seen_done | done;
        end
        check("ab_no_done", {31'b0, seen_done}, 0);
        check("ab_no_accept", {31'b0, busy}, 0);
        check("ab_pwm_stay", pwm_par, 0);

        // No-op command then back-to-back accept in the done cycle
        send(7'd0, 7'd5, 16'd0);
        tick();
        check("noop_busy", {31'b0, busy}, 1);
        check("noop_nodone", {31'b0, done}, 0);
        tick();
        check("noop_done", {31'b0, done}, 1);
        check("noop_ready", {31'b0, cmd_ready}, 1);
        send(7'd20, 7'd10, 16'd0);
        tick();
        cmd_valid = 1'b0;
        check("b2b_busy", {31'b0, busy}, 1);
        check("b2b_done_clr", {31'b0, done}, 0);
        repeat (10) tick();
        check("b2b_10", pwm_par, 10);
        repeat (10) tick();
        check("b2b_20", pwm_par, 20);
        tick();
        check("b2b_done", {31'b0, done}, 1);

        // Reset mid-ramp
        send(7'd100, 7'd10, 16'd0);
        tick();
        cmd_valid = 1'b0;
        repeat (15) tick();
        check("mid_pwm", pwm_par, 30);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_pwm", pwm_par, 0);
        check("mid_rst_busy", {31'b0, busy}, 0);
        check("mid_rst_done", {31'b0, done}, 0);
        tick();
        rst = 1'b0;
        tick();
        check("mid_rel_ready", {31'b0, cmd_ready}, 1);
        check("mid_rel_pwm", pwm_par, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
